// File: rtl/rtc_access_scheduler_if.sv
// Bus between the RTC emulation / I2C RTC controller and rtc_access_scheduler.
// The scheduler uses the slave modport.
interface rtc_access_scheduler_if;
  logic       emu_read_req;
  logic       emu_read_ack;
  logic       emu_write_req;
  logic       emu_write_ack;
  logic       refresh_enable;
  logic       rtc_read;
  logic       rtc_write;
  logic       rtc_ack;
  logic       busy;
  logic       error;
  logic [7:0] fail_count;

  modport slave (
    input  emu_read_req, emu_write_req, refresh_enable, rtc_ack,
    output emu_read_ack, emu_write_ack, rtc_read, rtc_write, busy, error, fail_count
  );

  modport master (
    output emu_read_req, emu_write_req, refresh_enable, rtc_ack,
    input  emu_read_ack, emu_write_ack, rtc_read, rtc_write, busy, error, fail_count
  );
endinterface

// File: rtl/rtc_access_scheduler.sv
// Serialises emulation reads/writes and periodic refresh reads onto the I2C RTC
// controller strobes, with a per-attempt timeout and bounded retry.
module rtc_access_scheduler #(
  parameter int REFRESH_CYCLES = 14187500,
  parameter int TIMEOUT_CYCLES = 141875,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                  clk14,
  input  logic                  reset_n,
  rtc_access_scheduler_if.slave io_bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] REF_RELOAD = TW'(REFRESH_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_holdoff;
  logic          r_op_wr;
  logic          r_op_emu;
  logic [CW-1:0] r_tmo_cnt;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_refresh_tmr;
  logic          r_refresh_pending;
  logic          r_rtc_read;
  logic          r_rtc_write;
  logic          r_emu_read_ack;
  logic          r_emu_write_ack;
  logic          r_busy;
  logic          r_error;
  logic [7:0]    r_fail_count;

  logic w_timeout;
  logic w_start_wr;
  logic w_start_rd;
  logic w_start_emu;
  logic w_ok;
  logic w_fail;
  logic w_retry_inc;

  // Next-state and transaction-event decode
  always_comb begin
    w_next      = r_state;
    w_start_wr  = 1'b0;
    w_start_rd  = 1'b0;
    w_start_emu = 1'b0;
    w_ok        = 1'b0;
    w_fail      = 1'b0;
    w_retry_inc = 1'b0;
    w_timeout   = (r_tmo_cnt == TMO_LAST);
    case (r_state)
      S_IDLE: begin
        // the hold-off cycle keeps a requester's still-high req from re-entering
        if (r_holdoff) begin
          w_next = S_IDLE;
        end else if (io_bus.emu_write_req) begin
          w_next     = S_WR;
          w_start_wr = 1'b1;
        end else if (io_bus.emu_read_req) begin
          w_next      = S_RD;
          w_start_rd  = 1'b1;
          w_start_emu = 1'b1;
        end else if (r_refresh_pending) begin
          w_next     = S_RD;
          w_start_rd = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD, S_WR: begin
        if (io_bus.rtc_ack) begin
          w_next = S_DONE;
          w_ok   = 1'b1;
        end else if (w_timeout) begin
          if (r_retry < RETRY_MAX) begin
            w_next      = S_GAP;
            w_retry_inc = 1'b1;
          end else begin
            w_next = S_DONE;
            w_fail = 1'b1;
          end
        end else begin
          w_next = r_state;
        end
      end
      S_GAP:   w_next = r_op_wr ? S_WR : S_RD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and arbitration hold-off flag
  always_ff @(posedge clk14) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_holdoff <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_holdoff <= (r_state == S_DONE);
    end
  end

  // Transaction owner, captured at arbitration; writes always belong to the emulation
  always_ff @(posedge clk14) begin
    if (!reset_n) begin
      r_op_wr  <= 1'b0;
      r_op_emu <= 1'b0;
    end else if (w_start_wr || w_start_rd) begin
      r_op_wr  <= w_start_wr;
      r_op_emu <= w_start_wr | w_start_emu;
    end
  end

  // Per-attempt timeout counter and retry count
  always_ff @(posedge clk14) begin
    if (!reset_n) begin
      r_tmo_cnt <= {CW{1'b0}};
      r_retry   <= {RW{1'b0}};
    end else begin
      if (((r_state == S_RD) || (r_state == S_WR)) && (w_next == r_state)) begin
        r_tmo_cnt <= r_tmo_cnt + CW'(1);
      end else begin
        r_tmo_cnt <= {CW{1'b0}};
      end
      if (w_retry_inc) begin
        r_retry <= r_retry + RW'(1);
      end else if (r_state == S_DONE) begin
        r_retry <= {RW{1'b0}};
      end
    end
  end

  // Refresh timer; a read finishing in DONE overrides a same-cycle expiry
  always_ff @(posedge clk14) begin
    if (!reset_n) begin
      r_refresh_pending <= 1'b1;
      r_refresh_tmr     <= REF_RELOAD;
    end else if ((r_state == S_DONE) && !r_op_wr) begin
      r_refresh_pending <= 1'b0;
      r_refresh_tmr     <= REF_RELOAD;
    end else if (io_bus.refresh_enable) begin
      if (r_refresh_tmr == {TW{1'b0}}) begin
        r_refresh_pending <= 1'b1;
        r_refresh_tmr     <= REF_RELOAD;
      end else begin
        r_refresh_tmr <= r_refresh_tmr - TW'(1);
      end
    end
  end

  // Registered strobes, acks and status, all decoded from the next state
  always_ff @(posedge clk14) begin
    if (!reset_n) begin
      r_rtc_read      <= 1'b0;
      r_rtc_write     <= 1'b0;
      r_busy          <= 1'b0;
      r_emu_read_ack  <= 1'b0;
      r_emu_write_ack <= 1'b0;
      r_error         <= 1'b0;
      r_fail_count    <= 8'd0;
    end else begin
      r_rtc_read      <= (w_next == S_RD);
      r_rtc_write     <= (w_next == S_WR);
      r_busy          <= (w_next != S_IDLE);
      r_emu_read_ack  <= (w_ok | w_fail) & ~r_op_wr & r_op_emu;
      r_emu_write_ack <= (w_ok | w_fail) & r_op_wr;
      if (w_ok) begin
        r_error <= 1'b0;
      end else if (w_fail) begin
        r_error <= 1'b1;
        if (r_fail_count != 8'hFF) begin
          r_fail_count <= r_fail_count + 8'd1;
        end
      end
    end
  end

  assign io_bus.rtc_read      = r_rtc_read;
  assign io_bus.rtc_write     = r_rtc_write;
  assign io_bus.busy          = r_busy;
  assign io_bus.emu_read_ack  = r_emu_read_ack;
  assign io_bus.emu_write_ack = r_emu_write_ack;
  assign io_bus.error         = r_error;
  assign io_bus.fail_count    = r_fail_count;

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Scoreboard bench for rtc_access_scheduler: a behavioural RTC controller answers
// strobes, and each completed transaction is checked against queued expectations.
module tb_rtc_access_scheduler;
  localparam int REFRESH = 100;
  localparam int TMO     = 20;
  localparam int RETRIES = 2;

  localparam int K_REFRESH = 0;
  localparam int K_EMU_RD  = 1;
  localparam int K_EMU_WR  = 2;

  logic clk14 = 1'b0;
  logic reset_n;
  always #5 clk14 = ~clk14;

  rtc_access_scheduler_if bus();

  rtc_access_scheduler #(
    .REFRESH_CYCLES(REFRESH),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRIES(RETRIES)
  ) dut (
    .clk14(clk14),
    .reset_n(reset_n),
    .io_bus(bus)
  );

  typedef struct {
    int kind;
    int err;
    int fc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   age = 0;
  int   ack_delay = 5;
  bit   ack_en = 1'b1;
  bit   wack_prev = 1'b0;
  bit   rack_prev = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int kind, input int err, input int fc);
    exp_t e;
    e.kind = kind;
    e.err  = err;
    e.fc   = fc;
    sb.push_back(e);
  endtask

  // One clock: RTC controller model and requester contract, driven just after the edge
  task automatic tick();
    @(posedge clk14);
    #1;
    cyc++;
    bus.rtc_ack = 1'b0;
    if (bus.rtc_read || bus.rtc_write) begin
      age++;
      if (ack_en && age == ack_delay) bus.rtc_ack = 1'b1;
    end else begin
      age = 0;
    end
    if (wack_prev) bus.emu_write_req = 1'b0;
    if (rack_prev) bus.emu_read_req  = 1'b0;
    wack_prev = bus.emu_write_ack;
    rack_prev = bus.emu_read_ack;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (bus.busy && n < bound) begin
      tick();
      n++;
    end
    check(tag, bus.busy, 0);
    tick();
    tick();
  endtask

  // Monitor: strobe exclusivity, and scoreboard pop whenever busy falls
  initial begin : monitor
    bit prev_busy = 1'b0;
    bit got_w = 1'b0;
    bit got_r = 1'b0;
    forever begin
      @(negedge clk14);
      if (!reset_n) begin
        prev_busy = 1'b0;
        got_w = 1'b0;
        got_r = 1'b0;
      end else begin
        if (bus.rtc_read || bus.rtc_write) check("strobe_overlap", bus.rtc_read & bus.rtc_write, 0);
        if (bus.emu_write_ack) got_w = 1'b1;
        if (bus.emu_read_ack)  got_r = 1'b1;
        if (prev_busy && !bus.busy) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_txn", sb.size(), 1);
          end else begin
            mon_e = sb.pop_front();
            check("sb_kind", got_w ? K_EMU_WR : (got_r ? K_EMU_RD : K_REFRESH), mon_e.kind);
            check("sb_error", bus.error, mon_e.err);
            check("sb_fail_count", bus.fail_count, mon_e.fc);
          end
          got_w = 1'b0;
          got_r = 1'b0;
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w, lw, n, rise1, period, ack_cyc, wr_during;
    reset_n = 1'b0;
    bus.emu_read_req   = 1'b0;
    bus.emu_write_req  = 1'b0;
    bus.refresh_enable = 1'b1;
    bus.rtc_ack        = 1'b0;
    repeat (3) tick();
    check("rst_rtc_read", bus.rtc_read, 0);
    check("rst_rtc_write", bus.rtc_write, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_error", bus.error, 0);
    check("rst_fail_count", bus.fail_count, 0);
    check("rst_acks", bus.emu_read_ack | bus.emu_write_ack, 0);

    // Boot refresh, then the periodic one
    push_exp(K_REFRESH, 0, 0);
    push_exp(K_REFRESH, 0, 0);
    ack_delay = 5;
    reset_n = 1'b1;
    tick();
    check("t1_rd_rise", bus.rtc_read, 1);
    rise1 = cyc;
    w = 0;
    while (bus.rtc_read && w < 50) begin
      w++;
      tick();
    end
    check("t1_ref_width", w, 5);
    check("t1_no_emu_ack", bus.emu_read_ack | bus.emu_write_ack, 0);
    n = 0;
    while (!bus.rtc_read && n < 200) begin
      tick();
      n++;
    end
    check("t1_second_refresh", bus.rtc_read, 1);
    period = cyc - rise1;
    check("t1_period_in_range", int'(period >= REFRESH && period <= REFRESH + 12), 1);
    bus.refresh_enable = 1'b0;
    wait_idle("t1_idle", 50);

    // Simultaneous write and read requests: write wins
    push_exp(K_EMU_WR, 0, 0);
    push_exp(K_EMU_RD, 0, 0);
    bus.emu_write_req = 1'b1;
    bus.emu_read_req  = 1'b1;
    tick();
    check("t2_wr_latency", bus.rtc_write, 1);
    check("t2_rd_low_during_wr", bus.rtc_read, 0);
    n = 0;
    while (bus.rtc_write && n < 50) begin
      tick();
      n++;
    end
    check("t2_wr_ack", bus.emu_write_ack, 1);
    lw = 0;
    while (!bus.rtc_read && lw < 50) begin
      lw++;
      tick();
    end
    check("t2_gap_ge3", int'(lw >= 3), 1);
    check("t2_rd_started", bus.rtc_read, 1);
    n = 0;
    while (bus.rtc_read && n < 50) begin
      tick();
      n++;
    end
    check("t2_rd_ack", bus.emu_read_ack, 1);
    wait_idle("t2_idle", 20);

    // Emu read never acknowledged: three timed-out attempts, then failure
    ack_en = 1'b0;
    push_exp(K_EMU_RD, 1, 1);
    bus.emu_read_req = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      w = 0;
      while (bus.rtc_read && w < 60) begin
        w++;
        tick();
      end
      check($sformatf("t3_pulse%0d_width", p), w, TMO);
      if (p < 2) begin
        if (p == 0) bus.rtc_ack = 1'b1;
        lw = 0;
        while (!bus.rtc_read && lw < 10) begin
          lw++;
          tick();
        end
        check($sformatf("t3_gap%0d_width", p), lw, 1);
      end
    end
    check("t3_read_ack", bus.emu_read_ack, 1);
    check("t3_error", bus.error, 1);
    check("t3_fail_count", bus.fail_count, 1);
    wait_idle("t3_idle", 20);

    ack_en = 1'b1;
    ack_delay = 3;
    push_exp(K_EMU_WR, 0, 1);
    bus.emu_write_req = 1'b1;
    tick();
    wait_idle("t3_wr_idle", 50);
    check("t3_error_cleared", bus.error, 0);
    check("t3_fail_count_kept", bus.fail_count, 1);

    // Refresh in flight is not preempted by a write
    push_exp(K_REFRESH, 0, 1);
    ack_delay = 8;
    bus.refresh_enable = 1'b1;
    n = 0;
    while (!bus.rtc_read && n < 200) begin
      tick();
      n++;
    end
    check("t4_refresh_start", bus.rtc_read, 1);
    bus.refresh_enable = 1'b0;
    repeat (3) tick();
    push_exp(K_EMU_WR, 0, 1);
    bus.emu_write_req = 1'b1;
    wr_during = 0;
    ack_cyc = -100;
    n = 0;
    while (bus.rtc_read && n < 50) begin
      tick();
      n++;
      if (bus.rtc_write) wr_during++;
      if (bus.rtc_ack) ack_cyc = cyc;
    end
    check("t4_no_preempt", wr_during, 0);
    n = 0;
    while (!bus.rtc_write && n < 20) begin
      tick();
      n++;
    end
    check("t4_wr_start", bus.rtc_write, 1);
    check("t4_wr_after_holdoff", int'(cyc - ack_cyc >= 4), 1);
    wait_idle("t4_idle", 50);

    // Stray ack while idle
    bus.rtc_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_stray_busy", bus.busy, 0);
      check("t5_stray_acks", bus.emu_read_ack | bus.emu_write_ack, 0);
    end
    check("t5_stray_fail_count", bus.fail_count, 1);

    // Reset while a write strobe is high
    ack_en = 1'b0;
    bus.emu_write_req = 1'b1;
    n = 0;
    while (!bus.rtc_write && n < 10) begin
      tick();
      n++;
    end
    check("t6_wr_up", bus.rtc_write, 1);
    repeat (2) tick();
    reset_n = 1'b0;
    bus.emu_write_req = 1'b0;
    sb.delete();
    tick();
    check("t6_wr_drop", bus.rtc_write, 0);
    check("t6_busy_drop", bus.busy, 0);
    check("t6_fail_count_clear", bus.fail_count, 0);
    tick();
    push_exp(K_REFRESH, 0, 0);
    ack_en = 1'b1;
    ack_delay = 4;
    reset_n = 1'b1;
    tick();
    check("t6_refresh_after_reset", bus.rtc_read, 1);
    wait_idle("t6_idle", 50);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rtc_access_scheduler.md
# rtc_access_scheduler

Sequences all transactions to the I2C RTC controller on the clk14 domain. It arbitrates between write and read requests from the RTC emulation and an internal periodic refresh timer. It drives the controller's level-held read/write strobes and guards each transaction with a timeout and bounded retry. A stalled I2C bus therefore never deadlocks the emulation.

## Interface
Parameters:
- REFRESH_CYCLES, 14187500, clk14 cycles between periodic refresh reads (1 s at 14.1875 MHz); minimum 16
- TIMEOUT_CYCLES, 141875, cycles a strobe may stay high without rtc_ack before a retry (10 ms)
- MAX_RETRIES, 2, retries after the first attempt before the transaction is declared failed

Ports:
- clk14  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- emu_read_req  in  1  level; emulation requests a read of the time registers
- emu_read_ack  out  1  one-cycle pulse; read request completed (success or failure)
- emu_write_req  in  1  level; emulation requests a write of the time registers
- emu_write_ack  out  1  one-cycle pulse; write request completed (success or failure)
- refresh_enable  in  1  1 = periodic refresh timer runs; 0 = timer holds its value
- rtc_read  out  1  read strobe to RTC controller, held until rtc_ack or timeout
- rtc_write  out  1  write strobe to RTC controller, held until rtc_ack or timeout
- rtc_ack  in  1  one-cycle completion pulse from RTC controller
- busy  out  1  high while not in IDLE
- error  out  1  sticky; set on failed transaction, cleared on next successful one
- fail_count  out  8  failed-transaction count, saturates at 255

## Operation
- States: IDLE, RD, WR, GAP, DONE.
- IDLE arbitration, evaluated every cycle, fixed priority:
  1. emu_write_req → WR
  2. emu_read_req → RD, marked as emu read
  3. refresh_pending → RD, marked as refresh
- RD/WR:
  - Drive rtc_read or rtc_write, never both; both are 0 outside RD/WR.
  - Timeout counter starts at 0 on entry and increments each cycle.
  - rtc_ack while in RD/WR means success → DONE.
  - rtc_ack in any other state is ignored.
- Timeout: counter reaches TIMEOUT_CYCLES-1 with no ack.
  - If retry < MAX_RETRIES: retry += 1 → GAP.
  - Otherwise: failure → DONE.
- GAP: strobe low for exactly 1 cycle, counter cleared, then return to the same RD/WR.
- DONE (1 cycle):
  - Pulse emu_read_ack or emu_write_ack per the transaction's owner; refresh reads pulse nothing.
  - Clear retry.
  - Any read, emu or refresh, success or fail: clear refresh_pending and reload the refresh timer.
  - Success: error ← 0.
  - Failure: error ← 1; fail_count += 1, saturating.
  - DONE is followed by one IDLE cycle in which arbitration is suppressed (hold-off), then normal IDLE.
- Refresh timer: down-counter from REFRESH_CYCLES-1, decrements when refresh_enable=1. At 0 it sets refresh_pending and reloads. A pending flag already set stays set; there is no queue.
- Requester contract:
  - Hold req until the matching ack.
  - Deassert req in the cycle after the ack.
  - The hold-off cycle guarantees a still-high req is not re-accepted.
- Simultaneous events:
  - A write request arriving during a refresh RD waits; it is not preempted.
  - The timer expiring in the same cycle as a read DONE leaves refresh_pending cleared; the DONE reload wins.

## Timing
- Reset values:
  - rtc_read, rtc_write, emu_read_ack, emu_write_ack, busy, error = 0; fail_count = 0.
  - State = IDLE; retry = 0.
  - refresh_pending = 1, so the first refresh is issued right after reset and the clock loads at boot.
  - Refresh timer = REFRESH_CYCLES-1.
- Request latency: req high at edge n → strobe high after edge n+1 (registered outputs).
- Ack latency: rtc_ack high at edge m → strobe low and emu ack high after edge m+1. Ack width is exactly 1 cycle.
- Next arbitration decision is no earlier than edge m+3.
- Minimum strobe-low gap between consecutive transactions or retries: 1 cycle.
- Worst-case transaction: (MAX_RETRIES+1)·TIMEOUT_CYCLES + MAX_RETRIES + 2 cycles.
- Reset mid-transaction:
  - Strobes drop on the next edge.
  - Pending acks are lost.
  - error and fail_count clear.
  - Refresh becomes pending again.

## Test plan
Bench parameters: REFRESH_CYCLES=100, TIMEOUT_CYCLES=20, MAX_RETRIES=2.
- Reset release, refresh_enable=1, controller acks 5 cycles after strobe:
  - rtc_read rises 1 cycle after reset release.
  - Falls 1 cycle after ack; no emu ack.
  - Next rtc_read about 100 cycles later.
- emu_write_req and emu_read_req raised in the same cycle:
  - rtc_write first, emu_write_ack pulse.
  - Then rtc_read, emu_read_ack pulse.
  - Strobes never overlap; at least 1 low cycle between them.
- Controller never acks an emu read:
  - 3 strobe pulses of 20 cycles each, separated by 1-cycle gaps.
  - Then emu_read_ack pulses, error=1, fail_count=1.
  - A later successful write clears error; fail_count stays 1.
- Refresh in flight, emu_write_req raised mid-transaction: refresh completes without interruption; rtc_write starts no earlier than 3 cycles after its rtc_ack.
- Stray rtc_ack while IDLE, and a second ack during GAP: no state change, no emu ack, fail_count unchanged.
- Assert reset_n=0 while rtc_write is high: rtc_write=0 after the next edge; after release, a refresh read is issued immediately.
